// File: rtl/fifo_wr_arbiter_if.sv
// Bus bundle for the FIFO write arbiter: two producer channels plus the FIFO write port.
interface fifo_wr_arbiter_if #(
    parameter int unsigned DW = 16
);
    logic          req0;
    logic          req1;
    logic [3:0]    len0;
    logic [3:0]    len1;
    logic [DW-1:0] din0;
    logic [DW-1:0] din1;
    logic          vld0;
    logic          vld1;
    logic          nfull;
    logic          err_clr;

    logic          gnt0;
    logic          gnt1;
    logic          rdy0;
    logic          rdy1;
    logic          done0;
    logic          done1;
    logic          fifo_wr;
    logic [DW-1:0] fifo_in;
    logic          error;
    logic          active;

    // Arbiter side
    modport slave (
        input  req0, req1, len0, len1, din0, din1, vld0, vld1, nfull, err_clr,
        output gnt0, gnt1, rdy0, rdy1, done0, done1, fifo_wr, fifo_in, error, active
    );

    // Producer / FIFO side
    modport master (
        output req0, req1, len0, len1, din0, din1, vld0, vld1, nfull, err_clr,
        input  gnt0, gnt1, rdy0, rdy1, done0, done1, fifo_wr, fifo_in, error, active
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between two burst producers,
// with backpressure support and abort of bursts whose owner stops supplying data.
module fifo_wr_arbiter #(
    parameter int unsigned DW        = 16,
    parameter int unsigned STALL_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.slave  bus
);

    localparam int unsigned REM_W  = 5;
    localparam int unsigned STALL_W = 8;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_ABORT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               last_q, last_d;
    logic [REM_W-1:0]   remain_q, remain_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               error_q, error_d;

    logic               win_c;
    logic               in_burst_c;
    logic               vld_sel_c;
    logic [DW-1:0]      din_sel_c;
    logic               accept_c;
    logic               done_c;

    // During a burst, last_q holds the channel that owns it
    always_comb begin
        in_burst_c = (state_q == S_BURST);
        vld_sel_c  = last_q ? bus.vld1 : bus.vld0;
        din_sel_c  = last_q ? bus.din1 : bus.din0;
        accept_c   = in_burst_c & vld_sel_c & bus.nfull;
        done_c     = accept_c & (remain_q == REM_W'(1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            remain_q <= '0;
            stall_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            remain_q <= remain_d;
            stall_q  <= stall_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        remain_d = remain_q;
        stall_d  = stall_q;
        error_d  = error_q;
        win_c    = 1'b0;

        if (bus.err_clr) error_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req0 | bus.req1) begin
                    // Tie goes to the channel not served last
                    win_c    = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
                    last_d   = win_c;
                    remain_d = REM_W'(win_c ? bus.len1 : bus.len0) + REM_W'(1);
                    stall_d  = '0;
                    state_d  = S_BURST;
                end
            end
            S_BURST: begin
                if (accept_c) begin
                    remain_d = remain_q - REM_W'(1);
                    stall_d  = '0;
                    if (remain_q == REM_W'(1)) state_d = S_IDLE;
                end else if (!vld_sel_c) begin
                    if (stall_q == STALL_LAST) state_d = S_ABORT;
                    else                       stall_d = stall_q + STALL_W'(1);
                end
            end
            S_ABORT: begin
                error_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Port-side decode; everything drops as soon as state leaves BURST
    assign bus.gnt0    = in_burst_c & ~last_q;
    assign bus.gnt1    = in_burst_c &  last_q;
    assign bus.rdy0    = accept_c & ~last_q;
    assign bus.rdy1    = accept_c &  last_q;
    assign bus.done0   = done_c & ~last_q;
    assign bus.done1   = done_c &  last_q;
    assign bus.fifo_wr = accept_c;
    assign bus.fifo_in = in_burst_c ? din_sel_c : '0;
    assign bus.error   = error_q;
    assign bus.active  = in_burst_c;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: arbitration order, burst framing,
// backpressure, starvation abort, max length and asynchronous reset.
module tb_fifo_wr_arbiter;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    fifo_wr_arbiter_if #(.DW(16)) bus ();

    fifo_wr_arbiter #(.DW(16), .STALL_MAX(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        bus.req0 = 0; bus.req1 = 0; bus.len0 = 0; bus.len1 = 0;
        bus.din0 = 0; bus.din1 = 0; bus.vld0 = 0; bus.vld1 = 0;
        bus.nfull = 1; bus.err_clr = 0;
        rst = 1;
        #1 rst = 0;
        #2;
        check("rst_gnt0", bus.gnt0, 0);
        check("rst_gnt1", bus.gnt1, 0);
        check("rst_wr", bus.fifo_wr, 0);
        check("rst_in", bus.fifo_in, 0);
        check("rst_err", bus.error, 0);
        check("rst_active", bus.active, 0);
        tick();
        rst = 1;

        // Round robin: both requesting, 2-word bursts, expect 0,1,0,1
        tick();
        bus.req0 = 1; bus.req1 = 1; bus.len0 = 1; bus.len1 = 1;
        bus.vld0 = 1; bus.vld1 = 1;
        #1;
        check("rr_idle0", bus.active, 0);
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < 2; w++) begin
                tick();
                bus.din0 = 16'(16'h1000 + b * 2 + w);
                bus.din1 = 16'(16'h2000 + b * 2 + w);
                if (b == 3 && w == 1) begin bus.req0 = 0; bus.req1 = 0; end
                #1;
                check("rr_gnt0", bus.gnt0, (b % 2) == 0);
                check("rr_gnt1", bus.gnt1, (b % 2) == 1);
                check("rr_wr", bus.fifo_wr, 1);
                check("rr_in", bus.fifo_in, ((b % 2) == 0) ? 32'(16'h1000 + b * 2 + w)
                                                          : 32'(16'h2000 + b * 2 + w));
                check("rr_done", (b % 2) == 0 ? bus.done0 : bus.done1, w == 1);
            end
            tick();
            #1;
            check("rr_gap", bus.active, 0);
            check("rr_gap_wr", bus.fifo_wr, 0);
        end
        bus.vld0 = 0; bus.vld1 = 0;

        // Single 4-word burst on channel 0
        tick();
        bus.req0 = 1; bus.len0 = 3; bus.vld0 = 1; bus.din0 = 16'hA000;
        #1;
        check("s_idle_gnt", bus.gnt0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.req0 = 0; bus.din0 = 16'(16'hA000 + i);
            #1;
            check("s_gnt0", bus.gnt0, 1);
            check("s_gnt1", bus.gnt1, 0);
            check("s_wr", bus.fifo_wr, 1);
            check("s_rdy0", bus.rdy0, 1);
            check("s_in", bus.fifo_in, 32'(16'hA000 + i));
            check("s_done0", bus.done0, i == 3);
        end
        tick();
        #1;
        check("s_end_gnt", bus.gnt0, 0);
        check("s_end_in", bus.fifo_in, 0);

        // Backpressure: 3-word burst, nfull low 20 cycles after the first word
        bus.din0 = 16'hC000; bus.len0 = 2; bus.req0 = 1;
        tick();
        bus.req0 = 0;
        #1;
        check("bp_w0_wr", bus.fifo_wr, 1);
        check("bp_w0_in", bus.fifo_in, 16'hC000);
        for (int i = 0; i < 20; i++) begin
            tick();
            bus.nfull = 0; bus.din0 = 16'hC001;
            #1;
            check("bp_stall_wr", bus.fifo_wr, 0);
            check("bp_stall_gnt", bus.gnt0, 1);
        end
        tick();
        bus.nfull = 1;
        #1;
        check("bp_w1_wr", bus.fifo_wr, 1);
        check("bp_w1_in", bus.fifo_in, 16'hC001);
        check("bp_w1_done", bus.done0, 0);
        tick();
        bus.din0 = 16'hC002;
        #1;
        check("bp_w2_wr", bus.fifo_wr, 1);
        check("bp_w2_done", bus.done0, 1);
        tick();
        bus.vld0 = 0;
        #1;
        check("bp_end_gnt", bus.gnt0, 0);
        check("bp_end_err", bus.error, 0);

        // Starvation abort on channel 1: one word of five, then vld1 drops
        bus.req1 = 1; bus.len1 = 4; bus.vld1 = 1; bus.din1 = 16'hD000;
        tick();
        bus.req1 = 0;
        #1;
        check("ab_w0_gnt1", bus.gnt1, 1);
        check("ab_w0_wr", bus.fifo_wr, 1);
        check("ab_w0_in", bus.fifo_in, 16'hD000);
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.vld1 = 0;
            #1;
            check("ab_starve_gnt1", bus.gnt1, 1);
            check("ab_starve_wr", bus.fifo_wr, 0);
            check("ab_starve_rdy1", bus.rdy1, 0);
        end
        tick();
        #1;
        check("ab_abort_active", bus.active, 0);
        check("ab_abort_gnt1", bus.gnt1, 0);
        check("ab_abort_done1", bus.done1, 0);
        check("ab_abort_err", bus.error, 0);
        tick();
        #1;
        check("ab_err_set", bus.error, 1);
        tick();
        bus.err_clr = 1;
        #1;
        check("ab_err_hold", bus.error, 1);
        tick();
        bus.err_clr = 0;
        #1;
        check("ab_err_clr", bus.error, 0);

        // Max length: len0=15 gives 16 words
        bus.req0 = 1; bus.len0 = 15; bus.vld0 = 1;
        for (int i = 0; i < 16; i++) begin
            tick();
            bus.req0 = 0; bus.din0 = 16'(16'hE000 + i);
            #1;
            check("ml_wr", bus.fifo_wr, 1);
            check("ml_in", bus.fifo_in, 32'(16'hE000 + i));
            check("ml_done", bus.done0, i == 15);
        end
        tick();
        #1;
        check("ml_end_gnt", bus.gnt0, 0);

        // Asynchronous reset during the 3rd word of an 8-word burst
        bus.req0 = 1; bus.len0 = 7;
        tick();
        bus.req0 = 0;
        tick();
        tick();
        #1;
        check("rs_pre_wr", bus.fifo_wr, 1);
        rst = 0;
        #1;
        check("rs_gnt0", bus.gnt0, 0);
        check("rs_wr", bus.fifo_wr, 0);
        check("rs_active", bus.active, 0);
        check("rs_err", bus.error, 0);
        tick();
        rst = 1;
        bus.req0 = 1; bus.req1 = 1; bus.len0 = 0; bus.len1 = 0; bus.vld1 = 1;
        #1;
        check("rs_idle", bus.active, 0);
        tick();
        bus.req0 = 0; bus.req1 = 0;
        #1;
        check("rs_tie_gnt0", bus.gnt0, 1);
        check("rs_tie_gnt1", bus.gnt1, 0);
        check("rs_tie_done0", bus.done0, 1);
        tick();
        #1;
        check("rs_final_active", bus.active, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
